// File: rtl/k_energy_envelope.sv
// k_energy_envelope
// Frame-based envelope follower for the compressor datapath. Per-bin energy
// samples are summed over FRAME_LEN bins into a frame mean, the frame peak is
// tracked alongside, and the mean is smoothed by an attack/release one-pole
// filter. The result goes to the gain computer over an AXI-Stream master port.
//
// Output handshake: m_axis_tvalid rises when a new envelope is ready and then
// stays high, with m_axis_tdata stable, until the edge where m_axis_tvalid and
// m_axis_tready are both high. On that edge the beat is transferred.
// m_axis_tvalid never depends combinationally on m_axis_tready. The input side
// has no backpressure. If a frame completes while an envelope is still
// waiting, the new frame is dropped and counted in drop_count.

module k_energy_envelope #(
    parameter int IN_WIDTH      = 40,
    parameter int LOG2_FRAME    = 9,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 6
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [IN_WIDTH-1:0] in_energy,
    input  logic                in_valid,
    output logic [IN_WIDTH-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [IN_WIDTH-1:0] frame_peak,
    output logic [15:0]         drop_count,
    output logic [1:0]          dbg_state
);

    // The accumulator carries LOG2_FRAME guard bits, so a full frame of
    // maximum-value samples cannot overflow it.
    localparam int ACC_W = IN_WIDTH + LOG2_FRAME;

    // FRAME_LEN-1 is all ones in a LOG2_FRAME-bit counter.
    localparam logic [LOG2_FRAME-1:0] LAST_BIN = '1;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // Envelope state machine encoding.
    localparam logic [1:0] S_ACCUM  = 2'd0;
    localparam logic [1:0] S_SMOOTH = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]      acc_q;
    logic [LOG2_FRAME-1:0] cnt_q;
    logic [IN_WIDTH-1:0]   run_peak_q;
    logic [IN_WIDTH-1:0]   frame_peak_q;

    logic [1:0]            state_q,  state_d;
    logic [IN_WIDTH-1:0]   mean_q,   mean_d;
    logic [IN_WIDTH-1:0]   env_q,    env_d;
    logic                  tvalid_q, tvalid_d;
    logic [15:0]           drop_q,   drop_d;

    // ------------------------------------------------------------------
    // Frame datapath (combinational)
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]      acc_sum;
    logic [IN_WIDTH-1:0]   frame_mean;
    logic [IN_WIDTH-1:0]   peak_next;
    logic                  frame_done;
    logic                  handshake;

    // Accumulate, take the floor mean, and update the running max.
    always_comb begin
        acc_sum    = acc_q + {{LOG2_FRAME{1'b0}}, in_energy};
        frame_mean = acc_sum[ACC_W-1:LOG2_FRAME];
        peak_next  = (in_energy > run_peak_q) ? in_energy : run_peak_q;
        frame_done = in_valid && (cnt_q == LAST_BIN);
        handshake  = tvalid_q && m_axis_tready;
    end

    // ------------------------------------------------------------------
    // Attack/release smoother (combinational)
    // ------------------------------------------------------------------
    logic                  rising;
    logic [IN_WIDTH-1:0]   diff_up;
    logic [IN_WIDTH-1:0]   diff_dn;
    logic [IN_WIDTH-1:0]   env_smoothed;

    // Each difference is taken larger-minus-smaller, so the step never moves
    // env past mean and env cannot wrap in either direction.
    always_comb begin
        rising  = mean_q > env_q;
        diff_up = mean_q - env_q;
        diff_dn = env_q - mean_q;
        if (rising) begin
            env_smoothed = env_q + (diff_up >> ATTACK_SHIFT);
        end else begin
            env_smoothed = env_q - (diff_dn >> RELEASE_SHIFT);
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulation (runs in every FSM state, input never stalls)
    // ------------------------------------------------------------------

    // Accumulate sum, running peak and bin count; clear at frame end.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            run_peak_q <= '0;
        end else if (in_valid) begin
            if (frame_done) begin
                acc_q      <= '0;
                cnt_q      <= '0;
                run_peak_q <= '0;
            end else begin
                acc_q      <= acc_sum;
                cnt_q      <= cnt_q + 1'b1;
                run_peak_q <= peak_next;
            end
        end
    end

    // Publish the peak of every completed frame, dropped frames included.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_peak_q <= '0;
        end else if (frame_done) begin
            frame_peak_q <= peak_next;
        end
    end

    // ------------------------------------------------------------------
    // Envelope FSM
    // ------------------------------------------------------------------

    // Next-state logic: latch mean, smooth once, hold the beat until taken.
    always_comb begin
        state_d  = state_q;
        mean_d   = mean_q;
        env_d    = env_q;
        tvalid_d = tvalid_q;
        drop_d   = drop_q;

        case (state_q)
            S_ACCUM: begin
                if (frame_done) begin
                    mean_d  = frame_mean;
                    state_d = S_SMOOTH;
                end
            end

            // A frame is at least four bins long, so no frame can complete
            // during this single cycle.
            S_SMOOTH: begin
                env_d    = env_smoothed;
                tvalid_d = 1'b1;
                state_d  = S_OUTPUT;
            end

            S_OUTPUT: begin
                if (handshake) begin
                    tvalid_d = 1'b0;
                    if (frame_done) begin
                        // The beat leaves on the same edge the new frame
                        // lands, so the new frame is kept, not dropped.
                        mean_d  = frame_mean;
                        state_d = S_SMOOTH;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else if (frame_done) begin
                    // Previous envelope not yet taken: discard this frame.
                    if (drop_q != DROP_MAX) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d  = S_ACCUM;
                tvalid_d = 1'b0;
            end
        endcase
    end

    // FSM and envelope registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_ACCUM;
            mean_q   <= '0;
            env_q    <= '0;
            tvalid_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            mean_q   <= mean_d;
            env_q    <= env_d;
            tvalid_q <= tvalid_d;
            drop_q   <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_axis_tdata  = env_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_peak    = frame_peak_q;
    assign drop_count    = drop_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_k_energy_envelope.sv
// Directed testbench for k_energy_envelope (LOG2_FRAME=2, ATTACK_SHIFT=1,
// RELEASE_SHIFT=2). Inputs change on the falling edge; outputs are sampled
// on the falling edge, half a cycle after the rising edge that updated them.

module tb_k_energy_envelope;

  localparam int W = 40;
  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_SMOOTH = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  logic         clk;
  logic         aresetn;
  logic [W-1:0] in_energy;
  logic         in_valid;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [W-1:0] frame_peak;
  logic [15:0]  drop_count;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  k_energy_envelope #(
    .IN_WIDTH     (W),
    .LOG2_FRAME   (2),
    .ATTACK_SHIFT (1),
    .RELEASE_SHIFT(2)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .in_energy    (in_energy),
    .in_valid     (in_valid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .frame_peak   (frame_peak),
    .drop_count   (drop_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    in_valid  = v;
    in_energy = d;
  endtask

  // Four samples; returns at the falling edge after the completing edge.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d,
                            input logic ready_on_last);
    drive(1'b1, a);
    drive(1'b1, b);
    drive(1'b1, c);
    drive(1'b1, d);
    if (ready_on_last) m_axis_tready = 1'b1;
    drive(1'b0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    aresetn       = 1'b0;
    m_axis_tready = 1'b0;
    in_valid      = 1'b0;
    in_energy     = '0;
    for (int i = 0; i < 6; i++) drive(i[0], 40'd55);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0d exp 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %0d exp 0", m_axis_tdata); end
    checks++; if (frame_peak !== '0) begin errors++; $display("FAIL reset_peak got %0d exp 0", frame_peak); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    checks++; if (dbg_state !== ST_ACCUM) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_ACCUM); end
    drive(1'b0, '0);
    aresetn = 1'b1;
  endtask

  task automatic test_first_frame();
    m_axis_tready = 1'b1;
    send_frame(40'd100, 40'd100, 40'd100, 40'd100, 1'b0);
    checks++; if (frame_peak !== 40'd100) begin errors++; $display("FAIL first_peak got %0d exp 100", frame_peak); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL first_tvalid_early got %0d exp 0", m_axis_tvalid); end
    checks++; if (dbg_state !== ST_SMOOTH) begin errors++; $display("FAIL first_state_smooth got %0d exp %0d", dbg_state, ST_SMOOTH); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL first_tvalid got %0d exp 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 40'd50) begin errors++; $display("FAIL first_tdata got %0d exp 50", m_axis_tdata); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL first_tvalid_drop got %0d exp 0", m_axis_tvalid); end
    checks++; if (dbg_state !== ST_ACCUM) begin errors++; $display("FAIL first_state_accum got %0d exp %0d", dbg_state, ST_ACCUM); end
  endtask

  task automatic test_attack_release();
    send_frame(40'd100, 40'd100, 40'd100, 40'd100, 1'b0);
    @(negedge clk);
    checks++; if (m_axis_tdata !== 40'd75) begin errors++; $display("FAIL attack_tdata got %0d exp 75", m_axis_tdata); end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL attack_tvalid got %0d exp 1", m_axis_tvalid); end
    @(negedge clk);
    send_frame(40'd0, 40'd0, 40'd0, 40'd0, 1'b0);
    checks++; if (frame_peak !== 40'd0) begin errors++; $display("FAIL release_peak got %0d exp 0", frame_peak); end
    @(negedge clk);
    checks++; if (m_axis_tdata !== 40'd57) begin errors++; $display("FAIL release_tdata got %0d exp 57", m_axis_tdata); end
    @(negedge clk);
  endtask

  task automatic test_floor_peak();
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(40'd1, 40'd2, 40'd3, 40'd7, 1'b0);
    checks++; if (frame_peak !== 40'd7) begin errors++; $display("FAIL floor_peak got %0d exp 7", frame_peak); end
    @(negedge clk);
    checks++; if (m_axis_tdata !== 40'd1) begin errors++; $display("FAIL floor_tdata got %0d exp 1", m_axis_tdata); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b0;
    send_frame(40'd40, 40'd40, 40'd40, 40'd40, 1'b0);
    @(negedge clk);
    checks++; if (m_axis_tdata !== 40'd20) begin errors++; $display("FAIL bp_tdata got %0d exp 20", m_axis_tdata); end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid got %0d exp 1", m_axis_tvalid); end
    send_frame(40'd80, 40'd80, 40'd80, 40'd80, 1'b0);
    checks++; if (m_axis_tdata !== 40'd20) begin errors++; $display("FAIL bp_tdata_held got %0d exp 20", m_axis_tdata); end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_held got %0d exp 1", m_axis_tvalid); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL bp_drop got %0d exp 1", drop_count); end
    checks++; if (frame_peak !== 40'd80) begin errors++; $display("FAIL bp_peak got %0d exp 80", frame_peak); end
    checks++; if (dbg_state !== ST_OUTPUT) begin errors++; $display("FAIL bp_state_output got %0d exp %0d", dbg_state, ST_OUTPUT); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_after got %0d exp 0", m_axis_tvalid); end
    checks++; if (dbg_state !== ST_ACCUM) begin errors++; $display("FAIL bp_state_accum got %0d exp %0d", dbg_state, ST_ACCUM); end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_same_edge();
    m_axis_tready = 1'b0;
    send_frame(40'd60, 40'd60, 40'd60, 40'd60, 1'b0);
    @(negedge clk);
    checks++; if (m_axis_tdata !== 40'd40) begin errors++; $display("FAIL se_first_tdata got %0d exp 40", m_axis_tdata); end
    send_frame(40'd100, 40'd100, 40'd100, 40'd100, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL se_tvalid_gap got %0d exp 0", m_axis_tvalid); end
    checks++; if (dbg_state !== ST_SMOOTH) begin errors++; $display("FAIL se_state got %0d exp %0d", dbg_state, ST_SMOOTH); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL se_drop got %0d exp 1", drop_count); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL se_tvalid got %0d exp 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 40'd70) begin errors++; $display("FAIL se_tdata got %0d exp 70", m_axis_tdata); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL se_tvalid_drop got %0d exp 0", m_axis_tvalid); end
  endtask

  task automatic test_extremes_reset();
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(MAXV, MAXV, MAXV, MAXV, 1'b0);
    checks++; if (frame_peak !== MAXV) begin errors++; $display("FAIL ext_peak got %0h exp %0h", frame_peak, MAXV); end
    @(negedge clk);
    checks++; if (m_axis_tdata !== 40'h7F_FFFF_FFFF) begin errors++; $display("FAIL ext_tdata got %0h exp 7fffffffff", m_axis_tdata); end
    @(negedge clk);
    drive(1'b1, 40'd5);
    drive(1'b1, 40'd5);
    @(negedge clk);
    in_valid = 1'b0;
    aresetn  = 1'b0;
    #1;
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %0h exp 0", m_axis_tdata); end
    checks++; if (frame_peak !== '0) begin errors++; $display("FAIL rst_peak got %0h exp 0", frame_peak); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0d exp 0", m_axis_tvalid); end
    checks++; if (dbg_state !== ST_ACCUM) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_ACCUM); end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    send_frame(40'd8, 40'd8, 40'd8, 40'd8, 1'b0);
    checks++; if (frame_peak !== 40'd8) begin errors++; $display("FAIL post_rst_peak got %0d exp 8", frame_peak); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL post_rst_tvalid got %0d exp 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 40'd4) begin errors++; $display("FAIL post_rst_tdata got %0d exp 4", m_axis_tdata); end
    @(negedge clk);
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_first_frame();
    test_attack_release();
    test_floor_peak();
    test_backpressure();
    test_same_edge();
    test_extremes_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
